// File: rtl/tx_frame_gen_pkg.sv
// Shared definitions for the TX test-stream source: payload modes, FSM states,
// default LFSR feedback mask and a saturating frame-counter helper.
package tx_frame_gen_pkg;

  typedef enum logic [1:0] {
    MODE_PRBS  = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_CONST = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tx_frame_gen_lfsr.sv
// Right-shifting Galois LFSR with load/advance controls. A zero seed would
// lock the register at zero, so it is replaced by all-ones on load.
module tx_frame_gen_lfsr #(
  parameter int                W    = 32,
  parameter logic [W-1:0]      TAPS = W'(32'h8020_0003)
) (
  input  logic         s_axi_aclk,
  input  logic         s_axi_aresetn,
  input  logic         load_i,
  input  logic [W-1:0] seed_i,
  input  logic         advance_i,
  output logic [W-1:0] state_o
);

  logic [W-1:0] state_q;
  logic [W-1:0] step_d;

  assign step_d  = {1'b0, state_q[W-1:1]} ^ (state_q[0] ? TAPS : {W{1'b0}});
  assign state_o = state_q;

  // LFSR state register: load has priority over advance
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q <= {W{1'b0}};
    end else if (load_i) begin
      state_q <= (seed_i == {W{1'b0}}) ? {W{1'b1}} : seed_i;
    end else if (advance_i) begin
      state_q <= step_d;
    end else begin
      state_q <= state_q;
    end
  end

endmodule

// File: rtl/tx_frame_gen.sv
// Framed AXI-Stream test source: PRBS/counter/constant payload with SOF/TLAST,
// programmable frame length, frame count and inter-frame gap.
module tx_frame_gen
  import tx_frame_gen_pkg::*;
#(
  parameter int                      C_DATA_WIDTH = 32,
  parameter logic [C_DATA_WIDTH-1:0] C_LFSR_TAPS  = C_DATA_WIDTH'(DEFAULT_TAPS),
  parameter int                      C_LEN_WIDTH  = 16
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic                    i_start,
  input  logic                    i_stop,
  input  logic [1:0]              i_mode,
  input  logic [C_DATA_WIDTH-1:0] i_seed,
  input  logic [C_LEN_WIDTH-1:0]  i_frame_len,
  input  logic [15:0]             i_frame_count,
  input  logic [7:0]              i_gap_len,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tvalid,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_sof,
  output logic                    m_axis_tlast,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [15:0]             o_frames_sent
);

  state_e                  state_q;
  mode_e                   mode_q;
  logic [C_LEN_WIDTH-1:0]  last_idx_q;
  logic [C_LEN_WIDTH-1:0]  beat_q;
  logic [15:0]             count_q;
  logic [7:0]              gap_q;
  logic [7:0]              gap_cnt_q;
  logic [C_DATA_WIDTH-1:0] cnt_q;
  logic                    stop_q;
  logic                    tvalid_q;
  logic                    sof_q;
  logic                    tlast_q;
  logic                    busy_q;
  logic                    done_q;
  logic [15:0]             frames_q;
  logic [C_DATA_WIDTH-1:0] lfsr_state_s;
  logic                    accept_s;
  logic                    run_end_s;

  assign accept_s  = tvalid_q & m_axis_tready;
  // Stop request in the same cycle as the final TLAST still ends the run
  assign run_end_s = ((count_q != 16'd0) && (sat_inc16(frames_q) == count_q)) || stop_q || i_stop;

  tx_frame_gen_lfsr #(
    .W    (C_DATA_WIDTH),
    .TAPS (C_LFSR_TAPS)
  ) u_lfsr (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .load_i        (state_q == ST_LOAD),
    .seed_i        (i_seed),
    .advance_i     (accept_s && (mode_q == MODE_PRBS)),
    .state_o       (lfsr_state_s)
  );

  // Run-control FSM, framing counters and registered stream outputs
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_PRBS;
      last_idx_q <= {C_LEN_WIDTH{1'b0}};
      beat_q     <= {C_LEN_WIDTH{1'b0}};
      count_q    <= 16'd0;
      gap_q      <= 8'd0;
      gap_cnt_q  <= 8'd0;
      cnt_q      <= {C_DATA_WIDTH{1'b0}};
      stop_q     <= 1'b0;
      tvalid_q   <= 1'b0;
      sof_q      <= 1'b0;
      tlast_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      frames_q   <= 16'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          stop_q <= i_start & i_stop;
          if (i_start) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        ST_LOAD: begin
          mode_q     <= (i_mode == MODE_RSVD) ? MODE_PRBS : mode_e'(i_mode);
          last_idx_q <= (i_frame_len == {C_LEN_WIDTH{1'b0}}) ? {C_LEN_WIDTH{1'b0}}
                                                             : i_frame_len - C_LEN_WIDTH'(1);
          count_q    <= i_frame_count;
          gap_q      <= i_gap_len;
          cnt_q      <= i_seed;
          frames_q   <= 16'd0;
          beat_q     <= {C_LEN_WIDTH{1'b0}};
          stop_q     <= stop_q | i_stop;
          tvalid_q   <= 1'b1;
          sof_q      <= 1'b1;
          tlast_q    <= (i_frame_len <= C_LEN_WIDTH'(1));
          state_q    <= ST_SEND;
        end
        ST_SEND: begin
          stop_q <= stop_q | i_stop;
          if (accept_s) begin
            if (mode_q == MODE_COUNT) begin
              cnt_q <= cnt_q + C_DATA_WIDTH'(1);
            end else begin
              cnt_q <= cnt_q;
            end
            if (tlast_q) begin
              frames_q <= sat_inc16(frames_q);
              beat_q   <= {C_LEN_WIDTH{1'b0}};
              if (run_end_s) begin
                state_q  <= ST_IDLE;
                tvalid_q <= 1'b0;
                sof_q    <= 1'b0;
                tlast_q  <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
              end else if (gap_q == 8'd0) begin
                sof_q   <= 1'b1;
                tlast_q <= (last_idx_q == {C_LEN_WIDTH{1'b0}});
              end else begin
                state_q   <= ST_GAP;
                gap_cnt_q <= gap_q;
                tvalid_q  <= 1'b0;
                sof_q     <= 1'b0;
                tlast_q   <= 1'b0;
              end
            end else begin
              beat_q  <= beat_q + C_LEN_WIDTH'(1);
              sof_q   <= 1'b0;
              tlast_q <= ((beat_q + C_LEN_WIDTH'(1)) == last_idx_q);
            end
          end
        end
        ST_GAP: begin
          if (stop_q || i_stop) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (gap_cnt_q <= 8'd1) begin
            state_q  <= ST_SEND;
            tvalid_q <= 1'b1;
            sof_q    <= 1'b1;
            tlast_q  <= (last_idx_q == {C_LEN_WIDTH{1'b0}});
          end else begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = (mode_q == MODE_PRBS) ? lfsr_state_s : cnt_q;
  assign m_axis_sof    = sof_q;
  assign m_axis_tlast  = tlast_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_frames_sent = frames_q;

endmodule

// File: tb/tb_tx_frame_gen.sv
// Scoreboard bench for tx_frame_gen: stimulus pushes model beats, a monitor
// pops them on every accepted beat and also checks hold stability and gaps.
module tb_tx_frame_gen;

  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        s_axi_aclk = 1'b0;
  logic        s_axi_aresetn = 1'b0;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic [1:0]  i_mode = 2'd0;
  logic [31:0] i_seed = 32'd0;
  logic [15:0] i_frame_len = 16'd0;
  logic [15:0] i_frame_count = 16'd0;
  logic [7:0]  i_gap_len = 8'd0;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_sof;
  logic        m_axis_tlast;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_frames_sent;

  tx_frame_gen dut (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .i_start       (i_start),
    .i_stop        (i_stop),
    .i_mode        (i_mode),
    .i_seed        (i_seed),
    .i_frame_len   (i_frame_len),
    .i_frame_count (i_frame_count),
    .i_gap_len     (i_gap_len),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_sof    (m_axis_sof),
    .m_axis_tlast  (m_axis_tlast),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_frames_sent (o_frames_sent)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int ready_pct = 100;
  int exp_gap = 0;
  int beats_acc = 0;
  int cyc = 0;
  int last_tlast_cyc = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] next_val(input logic [1:0] m, input logic [31:0] v);
    if (m == 2'd1) return v + 32'd1;
    if (m == 2'd2) return v;
    return (v >> 1) ^ (v[0] ? TAPS : 32'd0);
  endfunction

  // Reference model: enqueue every beat of nframes frames
  task automatic push_model(input logic [1:0] m, input logic [31:0] seed, input int len, input int nframes);
    logic [31:0] cur;
    int          l;
    l   = (len == 0) ? 1 : len;
    cur = seed;
    if ((m == 2'd0 || m == 2'd3) && seed == 32'd0) cur = 32'hFFFF_FFFF;
    for (int f = 0; f < nframes; f++) begin
      for (int b = 0; b < l; b++) begin
        sb.push_back('{data: cur, sof: (b == 0), last: (b == l - 1)});
        cur = next_val(m, cur);
      end
    end
  endtask

  task automatic tick_n();
    @(negedge s_axi_aclk);
    #1;
  endtask

  // Downstream ready generator
  initial forever begin
    @(posedge s_axi_aclk);
    #1 m_axis_tready = ($urandom_range(99) < ready_pct);
  end

  // Monitor: scoreboard pop, hold stability and inter-frame gap length
  initial begin : monitor
    bit          hold_v = 0;
    bit          in_gap = 0;
    int          gap_idle = 0;
    logic [31:0] h_data = 32'd0;
    logic        h_sof = 1'b0;
    logic        h_last = 1'b0;
    beat_t       e;
    forever begin
      @(negedge s_axi_aclk);
      cyc++;
      if (!s_axi_aresetn) begin
        hold_v = 0;
        in_gap = 0;
      end else begin
        if (hold_v)
          chk(m_axis_tvalid && m_axis_tdata == h_data && m_axis_sof == h_sof && m_axis_tlast == h_last,
              "hold_stable", {m_axis_tvalid, m_axis_sof, m_axis_tlast, m_axis_tdata},
              {1'b1, h_sof, h_last, h_data});
        if (in_gap) begin
          if (m_axis_tvalid) begin
            chk(gap_idle == exp_gap, "gap_len", gap_idle, exp_gap);
            in_gap = 0;
          end else if (!o_busy) begin
            in_gap = 0;
          end else begin
            gap_idle++;
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (sb.size() == 0) begin
            chk(1'b0, "unexpected_beat", m_axis_tdata, 0);
          end else begin
            e = sb.pop_front();
            chk(m_axis_tdata == e.data && m_axis_sof == e.sof && m_axis_tlast == e.last, "beat",
                {m_axis_sof, m_axis_tlast, m_axis_tdata}, {e.sof, e.last, e.data});
          end
          beats_acc++;
          if (m_axis_tlast) begin
            in_gap = 1;
            gap_idle = 0;
            last_tlast_cyc = cyc;
          end
          hold_v = 0;
        end else if (m_axis_tvalid) begin
          hold_v = 1;
          h_data = m_axis_tdata;
          h_sof  = m_axis_sof;
          h_last = m_axis_tlast;
        end else begin
          hold_v = 0;
        end
      end
    end
  end

  task automatic start_run(input logic [1:0] m, input logic [31:0] seed, input int len,
                           input int count, input int gap, input int rp, input int nframes);
    @(posedge s_axi_aclk);
    #1;
    i_mode = m; i_seed = seed; i_frame_len = 16'(len);
    i_frame_count = 16'(count); i_gap_len = 8'(gap);
    ready_pct = rp; exp_gap = gap;
    push_model(m, seed, len, nframes);
    i_start = 1'b1;
    @(posedge s_axi_aclk);
    #1 i_start = 1'b0;
    tick_n();
    chk(o_busy == 1'b1 && m_axis_tvalid == 1'b0, "load_cycle", {o_busy, m_axis_tvalid}, 2'b10);
    tick_n();
    chk(m_axis_tvalid == 1'b1, "start_latency", m_axis_tvalid, 1);
  endtask

  task automatic finish_run(input int exp_frames);
    int t;
    t = 0;
    while (!o_done && t < 5000) begin
      tick_n();
      t++;
    end
    chk(o_done == 1'b1, "done_timeout", o_done, 1);
    if (o_done) begin
      chk(cyc - last_tlast_cyc == 1, "done_after_tlast", cyc - last_tlast_cyc, 1);
      chk(o_frames_sent == 16'(exp_frames), "frames_sent", o_frames_sent, exp_frames);
      chk(!o_busy && !m_axis_tvalid, "idle_after_done", {o_busy, m_axis_tvalid}, 0);
      chk(sb.size() == 0, "beats_missing", sb.size(), 0);
      tick_n();
      chk(o_done == 1'b0, "done_pulse", o_done, 0);
    end
    sb.delete();
    repeat (3) tick_n();
  endtask

  task automatic wait_beats(input int target);
    int t;
    t = 0;
    while (beats_acc < target && t < 2000) begin
      tick_n();
      t++;
    end
    chk(beats_acc >= target, "beat_wait_timeout", beats_acc, target);
  endtask

  initial begin
    int base;
    tick_n();
    chk({m_axis_tvalid, m_axis_sof, m_axis_tlast, o_busy, o_done} == 5'd0 && m_axis_tdata == 32'd0
        && o_frames_sent == 16'd0, "reset_outputs",
        {m_axis_tvalid, m_axis_sof, m_axis_tlast, o_busy, o_done, m_axis_tdata}, 0);
    @(posedge s_axi_aclk);
    #1 s_axi_aresetn = 1'b1;
    repeat (2) tick_n();

    start_run(2'd0, 32'h1, 4, 2, 0, 100, 2);              finish_run(2);
    start_run(2'd1, 32'hFFFF_FFFE, 3, 1, 0, 100, 1);      finish_run(1);
    start_run(2'd0, 32'h1234_5678, 16, 3, 0, 50, 3);      finish_run(3);
    start_run(2'd1, 32'h10, 0, 2, 5, 100, 2);             finish_run(2);
    start_run(2'd3, 32'h55, 1, 2, 5, 100, 2);             finish_run(2);

    base = beats_acc;
    start_run(2'd2, 32'hCAFE_F00D, 8, 0, 2, 100, 2);
    wait_beats(base + 11);
    @(posedge s_axi_aclk);
    #1 i_stop = 1'b1;
    @(posedge s_axi_aclk);
    #1 i_stop = 1'b0;
    finish_run(2);

    for (int r = 0; r < 6; r++) begin
      int c;
      c = $urandom_range(1, 3);
      start_run(2'($urandom_range(3)), $urandom, $urandom_range(0, 6), c,
                $urandom_range(0, 3), $urandom_range(30, 100), c);
      finish_run(c);
    end

    base = beats_acc;
    start_run(2'd0, 32'hDEAD_BEEF, 8, 0, 0, 100, 1);
    wait_beats(base + 3);
    @(posedge s_axi_aclk);
    #1 s_axi_aresetn = 1'b0;
    tick_n();
    chk({m_axis_tvalid, m_axis_sof, m_axis_tlast, o_busy, o_done} == 5'd0 && m_axis_tdata == 32'd0
        && o_frames_sent == 16'd0, "midframe_reset",
        {m_axis_tvalid, m_axis_sof, m_axis_tlast, o_busy, o_done, m_axis_tdata}, 0);
    sb.delete();
    @(posedge s_axi_aclk);
    #1 s_axi_aresetn = 1'b1;
    repeat (2) tick_n();
    start_run(2'd0, 32'd0, 4, 1, 0, 100, 1);
    finish_run(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
